// File: rtl/boot_pkg.sv
// Shared types and ack codes for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    ACK,
    DONE,
    ERR
  } boot_state_e;

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;

endpackage

// File: rtl/boot_timeout_counter.sv
// Inter-byte idle counter; expired_o flags the cycle the limit is reached.
module boot_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clear_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART image loader: packs RX bytes into IMEM words, halts core until acked.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        im_wr_en,
  output logic [31:0] im_wr_addr,
  output logic [31:0] im_wr_data,
  output logic        core_halt,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int unsigned WIW = $clog2(MAX_WORDS + 1);

  boot_state_e state_q, state_d;

  logic [31:0]    len_q, len_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic [1:0]     bidx_q, bidx_d;
  logic [23:0]    word_q, word_d;

  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        halt_q, halt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic        in_frame;
  logic        tmo;
  logic        tx_hs;
  logic        last_word;
  logic [31:0] len_nxt;

  assign in_frame  = (state_q == LEN) || (state_q == DATA)
                  || (state_q == CSUM);
  assign tx_hs     = tx_valid_q && tx_ready;
  assign len_nxt   = {rx_data, len_q[31:8]};
  assign last_word = (32'(widx_q) + 32'd1) == len_q;

  boot_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (rx_valid || !in_frame),
    .en_i     (in_frame),
    .expired_o(tmo)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = LEN;
          len_d   = '0;
          widx_d  = '0;
          bidx_d  = '0;
          word_d  = '0;
          err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN: begin
        if (rx_valid) begin
          len_d  = len_nxt;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if ((len_nxt == 32'd0) || (len_nxt > MAX_WORDS))
              state_d = ERR;
            else
              state_d = DATA;
          end
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          bidx_d = bidx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {rx_data, word_q};
            wr_addr_d = BASE_ADDR + (32'(widx_q) << 2);
            widx_d    = widx_q + WIW'(1);
            if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = ACK;
`endif
            end
          end else begin
            // Bytes arrive LE, so shift in from the top
            word_d = {rx_data, word_q[23:8]};
          end
        end else if (tmo) begin
          state_d = ERR;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: begin
        if (rx_valid)
          state_d = (rx_data == sum_q) ? ACK : ERR;
        else if (tmo)
          state_d = ERR;
      end
`endif
      ACK: begin
        if (tx_hs) state_d = DONE;
      end
      ERR: begin
        if (tx_hs) state_d = IDLE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_valid_d = (state_d == ACK) || (state_d == ERR);
    tx_data_d  = (state_d == ERR) ? ACK_ERR
               : (state_d == ACK) ? ACK_OK : 8'h00;
    halt_d     = (state_d != DONE);
    done_d     = (state_d == DONE);
    if (state_d == ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      halt_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign im_wr_en   = wr_en_q;
  assign im_wr_addr = wr_addr_q;
  assign im_wr_data = wr_data_q;
  assign core_halt  = halt_q;
  assign boot_done  = done_q;
  assign boot_err   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader (timeout shortened to 100).
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        im_wr_en;
  logic [31:0] im_wr_addr;
  logic [31:0] im_wr_data;
  logic        core_halt;
  logic        boot_done;
  logic        boot_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] wr_q[$];

  uart_boot_loader #(
    .BASE_ADDR     (32'h8000_0000),
    .MAX_WORDS     (1024),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .im_wr_en  (im_wr_en),
    .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data),
    .core_halt (core_halt),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (im_wr_en) wr_q.push_back({im_wr_addr, im_wr_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int lim, output bit seen,
                         output logic [7:0] d);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) seen = 1'b1;
    end
    d = tx_data;
  endtask

  task automatic tx_ack();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    rst_n = 1'b0;
    @(negedge clk);
    flags = {core_halt, boot_done, boot_err, tx_valid, im_wr_en};
    tests_run++;
    if (flags !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 10000", flags);
    end
    tests_run++;
    if (im_wr_addr !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h want 80000000", im_wr_addr);
    end
    tests_run++;
    if ({im_wr_data, tx_data} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h want 0/0",
               im_wr_data, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
  endtask

  task automatic test_single_word();
    bit seen;
    logic [7:0] d;
    logic [63:0] w;
    apply_reset();
    send_hdr(32'd1);
    send_word(32'h0000_0013);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h13);
`endif
    wait_tx(10, seen, d);
    tests_run++;
    if ({seen, d} !== {1'b1, 8'h4B}) begin
      tests_failed++;
      $display("FAIL single_ack: got seen=%0b %h want 1 4b", seen, d);
    end
    tests_run++;
    if (wr_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_wr_cnt: got %0d want 1", wr_q.size());
    end
    w = (wr_q.size() > 0) ? wr_q[0] : 64'hx;
    tests_run++;
    if (w !== {32'h8000_0000, 32'h0000_0013}) begin
      tests_failed++;
      $display("FAIL single_wr: got %h want 8000000000000013", w);
    end
    tests_run++;
    if (core_halt !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_halt_pre: got %b want 1", core_halt);
    end
    tx_ack();
    tests_run++;
    if ({core_halt, boot_done, tx_valid} !== 3'b010) begin
      tests_failed++;
      $display("FAIL single_done: got %b want 010",
               {core_halt, boot_done, tx_valid});
    end
    send_hdr(32'd1);
    send_word(32'h1111_1111);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({boot_done, tx_valid, 32'(wr_q.size())} !== {2'b10, 32'd1}) begin
      tests_failed++;
      $display("FAIL done_ignore: got done=%b txv=%b wr=%0d want 1 0 1",
               boot_done, tx_valid, wr_q.size());
    end
  endtask

  task automatic test_three_words();
    bit seen;
    logic [7:0] d;
    logic [63:0] exp_w[3];
    exp_w[0] = {32'h8000_0000, 32'h0403_0201};
    exp_w[1] = {32'h8000_0004, 32'h0807_0605};
    exp_w[2] = {32'h8000_0008, 32'h0C0B_0A09};
    apply_reset();
`ifdef BOOT_CHECKSUM_EN
    send_hdr(32'd3);
    for (int i = 0; i < 3; i++) send_word(exp_w[i][31:0]);
    send_byte(8'h00);
    wait_tx(10, seen, d);
    tests_run++;
    if ({seen, d} !== {1'b1, 8'h45}) begin
      tests_failed++;
      $display("FAIL badsum_ack: got seen=%0b %h want 1 45", seen, d);
    end
    tests_run++;
    if (wr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL badsum_wr_cnt: got %0d want 3", wr_q.size());
    end
    tx_ack();
    tests_run++;
    if ({boot_err, core_halt, boot_done} !== 3'b110) begin
      tests_failed++;
      $display("FAIL badsum_flags: got %b want 110",
               {boot_err, core_halt, boot_done});
    end
    wr_q.delete();
`endif
    send_hdr(32'd3);
    tests_run++;
    if (boot_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_clears_err: got %b want 0", boot_err);
    end
    for (int i = 0; i < 3; i++) send_word(exp_w[i][31:0]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h4E);
`endif
    wait_tx(10, seen, d);
    tests_run++;
    if ({seen, d} !== {1'b1, 8'h4B}) begin
      tests_failed++;
      $display("FAIL three_ack: got seen=%0b %h want 1 4b", seen, d);
    end
    tests_run++;
    if (wr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL three_wr_cnt: got %0d want 3", wr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [63:0] w;
      w = (wr_q.size() > i) ? wr_q[i] : 64'hx;
      tests_run++;
      if (w !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL three_wr%0d: got %h want %h", i, w, exp_w[i]);
      end
    end
    tx_ack();
    tests_run++;
    if ({boot_done, core_halt, boot_err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL three_done: got %b want 100",
               {boot_done, core_halt, boot_err});
    end
  endtask

  task automatic test_len_bounds();
    logic [31:0] lens[2];
    lens[0] = 32'd0;
    lens[1] = 32'd1025;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      send_hdr(lens[i]);
      tests_run++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h45}) begin
        tests_failed++;
        $display("FAIL len%0d_err: got %b %h want 1 45",
                 lens[i], tx_valid, tx_data);
      end
      tx_ack();
      tests_run++;
      if ({boot_err, tx_valid, core_halt} !== 3'b101) begin
        tests_failed++;
        $display("FAIL len%0d_flags: got %b want 101",
                 lens[i], {boot_err, tx_valid, core_halt});
      end
    end
    tests_run++;
    if (wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL len_wr_cnt: got %0d want 0", wr_q.size());
    end
  endtask

  task automatic test_timeout();
    bit seen;
    logic [7:0] d;
    apply_reset();
    send_hdr(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (95) @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_early: got tx_valid %b want 0", tx_valid);
    end
    wait_tx(20, seen, d);
    tests_run++;
    if ({seen, d} !== {1'b1, 8'h45}) begin
      tests_failed++;
      $display("FAIL tmo_err: got seen=%0b %h want 1 45", seen, d);
    end
    tests_run++;
    if (wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL tmo_partial: got %0d writes want 0", wr_q.size());
    end
    tx_ack();
    tests_run++;
    if ({boot_err, core_halt} !== 2'b11) begin
      tests_failed++;
      $display("FAIL tmo_flags: got %b want 11", {boot_err, core_halt});
    end
  endtask

  task automatic test_tx_hold();
    bit seen;
    bit stable;
    logic [7:0] d;
    apply_reset();
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h38);
`endif
    wait_tx(10, seen, d);
    stable = seen;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h4B && boot_done === 1'b0))
        stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_stable: got %b want 1 (txv=%b %h done=%b)",
               stable, tx_valid, tx_data, boot_done);
    end
    tx_ack();
    tests_run++;
    if ({boot_done, tx_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL hold_done: got %b want 10", {boot_done, tx_valid});
    end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    logic [7:0] d;
    logic [63:0] w;
    logic [36:0] snap;
    apply_reset();
    send_hdr(32'd4);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    send_byte(8'h77);
    w = (wr_q.size() > 1) ? wr_q[1] : 64'hx;
    tests_run++;
    if (w !== {32'h8000_0004, 32'h9ABC_DEF0}) begin
      tests_failed++;
      $display("FAIL mid_wr1: got %h want 800000049abcdef0", w);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    snap = {core_halt, boot_done, boot_err, tx_valid, im_wr_en,
            im_wr_addr};
    tests_run++;
    if (snap !== {5'b10000, 32'h8000_0000} || im_wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: got %h/%h want 1080000000/0",
               snap, im_wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    send_hdr(32'd1);
    send_word(32'hCAFE_F00D);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hC5);
`endif
    wait_tx(10, seen, d);
    tests_run++;
    if ({seen, d} !== {1'b1, 8'h4B}) begin
      tests_failed++;
      $display("FAIL mid_fresh_ack: got seen=%0b %h want 1 4b", seen, d);
    end
    w = (wr_q.size() == 1) ? wr_q[0] : 64'hx;
    tests_run++;
    if (w !== {32'h8000_0000, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL mid_fresh_wr: got %h (n=%0d) want 80000000cafef00d",
               w, wr_q.size());
    end
    tx_ack();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_len_bounds();
    test_timeout();
    test_tx_hold();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
